// File: rtl/asp_mem_router_pkg.sv
// Shared types and helpers for the ASP local-memory bank router.
package asp_mem_router_pkg;

  localparam int unsigned BANK_SEL_W = 3;
  localparam int unsigned RD_CNT_W   = $clog2(256) + 1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WR_BURST = 1'b1
  } t_router_state;

  // mode=0: bank field sits above the bank address; mode=1: bank field sits above the granule
  function automatic logic [BANK_SEL_W-1:0] bank_sel(
    input logic [63:0]  addr,
    input logic         mode,
    input int unsigned  sel_bits,
    input int unsigned  contig_lsb,
    input int unsigned  intlv_lsb
  );
    logic [63:0] w_shift;
    logic [63:0] w_mask;
    w_mask  = (64'd1 << sel_bits) - 64'd1;
    w_shift = mode ? (addr >> intlv_lsb) : (addr >> contig_lsb);
    return BANK_SEL_W'(w_shift & w_mask);
  endfunction

endpackage

// File: rtl/asp_bank_perf_counter.sv
// Saturating event counter with synchronous clear.
module asp_bank_perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/asp_local_mem_bank_router.sv
// Flat Avalon-MM burst slave fanned out to NUM_BANKS bank masters, in-order reads, bank-locked write bursts.
// Per-bank beat counters are built only when ASP_BANK_ROUTER_PERF_EN is defined.
module asp_local_mem_bank_router
  import asp_mem_router_pkg::*;
#(
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned BANK_ADDR_W  = 27,
  parameter int unsigned BURST_W      = 7,
  parameter int unsigned MAX_RD_BEATS = 256,
  parameter int unsigned INTERLEAVE   = 0,
  parameter int unsigned INTLV_LOG2   = 6
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [BANK_ADDR_W+$clog2(NUM_BANKS)-1:0]  s_address,
  input  logic [BURST_W-1:0]                        s_burstcount,
  input  logic                                      s_read,
  input  logic                                      s_write,
  input  logic [DATA_W-1:0]                         s_writedata,
  input  logic [DATA_W/8-1:0]                       s_byteenable,
  output logic                                      s_waitrequest,
  output logic [DATA_W-1:0]                         s_readdata,
  output logic                                      s_readdatavalid,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0]          m_address,
  output logic [NUM_BANKS*BURST_W-1:0]              m_burstcount,
  output logic [NUM_BANKS-1:0]                      m_read,
  output logic [NUM_BANKS-1:0]                      m_write,
  output logic [NUM_BANKS*DATA_W-1:0]               m_writedata,
  output logic [NUM_BANKS*DATA_W/8-1:0]             m_byteenable,
  input  logic [NUM_BANKS-1:0]                      m_waitrequest,
  input  logic [NUM_BANKS*DATA_W-1:0]               m_readdata,
  input  logic [NUM_BANKS-1:0]                      m_readdatavalid,
  output logic                                      err_burst_cross,
  output logic [NUM_BANKS*32-1:0]                   perf_rd_beats,
  output logic [NUM_BANKS*32-1:0]                   perf_wr_beats
);

  localparam int unsigned LOG2B = $clog2(NUM_BANKS);
  localparam int unsigned AW    = BANK_ADDR_W + LOG2B;
  localparam int unsigned BEW   = DATA_W / 8;
  localparam int unsigned RD_W  = $clog2(MAX_RD_BEATS) + 1;
  localparam int unsigned GRAN  = 1 << INTLV_LOG2;

  t_router_state           r_state;
  logic [BANK_SEL_W-1:0]   r_wr_bank;
  logic [BANK_SEL_W-1:0]   r_rd_bank;
  logic [BURST_W-1:0]      r_wr_left;
  logic [RD_W-1:0]         r_rd_beats_out;
  logic                    r_rdv;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;

  logic [BANK_SEL_W-1:0]   w_dec_bank;
  logic [BANK_SEL_W-1:0]   w_bank;
  logic [BANK_ADDR_W-1:0]  w_baddr;
  logic [NUM_BANKS-1:0]    w_sel;
  logic [NUM_BANKS-1:0]    w_rd_sel;
  logic                    w_bank_wait;
  logic                    w_ret_raw;
  logic                    w_ret;
  logic [DATA_W-1:0]       w_ret_data;
  logic [31:0]             w_rd_sum;
  logic                    w_rd_stall;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic                    w_first;
  logic                    w_cross;

  always_comb begin
    w_dec_bank = bank_sel(64'(s_address), INTERLEAVE != 0, LOG2B, BANK_ADDR_W, INTLV_LOG2);
    w_bank     = (r_state == WR_BURST) ? r_wr_bank : w_dec_bank;
    // interleaved: squeeze the bank field out, keeping granule offset in the low bits
    if ((INTERLEAVE != 0) && (LOG2B != 0)) begin
      w_baddr = BANK_ADDR_W'((s_address >> (INTLV_LOG2 + LOG2B)) << INTLV_LOG2)
              | BANK_ADDR_W'(s_address & AW'(GRAN - 1));
    end else begin
      w_baddr = s_address[BANK_ADDR_W-1:0];
    end
    w_cross = (INTERLEAVE != 0) &&
              ((64'(s_address & AW'(GRAN - 1)) + 64'(s_burstcount)) > 64'(GRAN));
  end

  always_comb begin
    w_bank_wait = 1'b0;
    w_ret_raw   = 1'b0;
    w_ret_data  = '0;
    w_sel       = '0;
    w_rd_sel    = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      w_sel[b]    = (w_bank == BANK_SEL_W'(b));
      w_rd_sel[b] = (r_rd_bank == BANK_SEL_W'(b));
      if (w_sel[b]) w_bank_wait = m_waitrequest[b];
      if (w_rd_sel[b]) begin
        w_ret_raw  = m_readdatavalid[b];
        w_ret_data = m_readdata[b*DATA_W +: DATA_W];
      end
    end
    // beats with nothing outstanding (e.g. stragglers after reset) are dropped
    w_ret = w_ret_raw & (r_rd_beats_out != '0);

    w_rd_sum   = 32'(r_rd_beats_out) + 32'(s_burstcount);
    w_rd_stall = s_read & ((r_state == WR_BURST) |
                           ((r_rd_beats_out != '0) & (w_dec_bank != r_rd_bank)) |
                           (w_rd_sum > MAX_RD_BEATS));
    s_waitrequest = reset | w_bank_wait | w_rd_stall;
    w_rd_acc      = s_read & ~s_waitrequest;
    w_wr_acc      = s_write & ~s_waitrequest;
    w_first       = w_rd_acc | (w_wr_acc & (r_state == IDLE));
  end

  always_comb begin
    m_address    = '0;
    m_burstcount = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    m_read       = '0;
    m_write      = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      m_address[b*BANK_ADDR_W +: BANK_ADDR_W] = w_baddr;
      m_burstcount[b*BURST_W +: BURST_W]      = s_burstcount;
      m_writedata[b*DATA_W +: DATA_W]         = s_writedata;
      m_byteenable[b*BEW +: BEW]              = s_byteenable;
      m_read[b]  = ~reset & s_read & ~w_rd_stall & w_sel[b];
      m_write[b] = ~reset & s_write & w_sel[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_wr_bank      <= '0;
      r_wr_left      <= '0;
      r_rd_bank      <= '0;
      r_rd_beats_out <= '0;
      r_rdv          <= 1'b0;
      r_rdata        <= '0;
      r_err          <= 1'b0;
    end else begin
      r_rdv   <= w_ret;
      r_rdata <= w_ret_data;
      if (w_first && w_cross) r_err <= 1'b1;
      if (w_rd_acc) r_rd_bank <= w_dec_bank;
      r_rd_beats_out <= RD_W'(32'(r_rd_beats_out)
                              + (w_rd_acc ? 32'(s_burstcount) : 32'd0)
                              - (w_ret ? 32'd1 : 32'd0));
      case (r_state)
        IDLE: begin
          if (w_wr_acc && (s_burstcount > BURST_W'(1))) begin
            r_state   <= WR_BURST;
            r_wr_bank <= w_dec_bank;
            r_wr_left <= s_burstcount - BURST_W'(1);
          end
        end
        WR_BURST: begin
          if (w_wr_acc) begin
            r_wr_left <= r_wr_left - BURST_W'(1);
            if (r_wr_left == BURST_W'(1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rdv_from_rd_bank: assert ((m_readdatavalid & ~w_rd_sel) == '0);
    end
  end

  assign s_readdatavalid = r_rdv;
  assign s_readdata      = r_rdata;
  assign err_burst_cross = r_err;

`ifdef ASP_BANK_ROUTER_PERF_EN
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_perf
    asp_bank_perf_counter #(.WIDTH(32)) u_rd_cnt (
      .clk     (clk),
      .i_clear (reset),
      .i_inc   (m_readdatavalid[g]),
      .o_count (perf_rd_beats[g*32 +: 32])
    );
    asp_bank_perf_counter #(.WIDTH(32)) u_wr_cnt (
      .clk     (clk),
      .i_clear (reset),
      .i_inc   (m_write[g] & ~m_waitrequest[g]),
      .o_count (perf_wr_beats[g*32 +: 32])
    );
  end
`else
  assign perf_rd_beats = '0;
  assign perf_wr_beats = '0;
`endif

endmodule

// File: tb/tb_asp_local_mem_bank_router.sv
// Directed bench: contiguous 4-bank router, interleaved router, and a narrow standalone perf counter.
module tb_asp_local_mem_bank_router;

  localparam int unsigned DW = 32;
  localparam int unsigned NB = 4;
  localparam int unsigned BA = 27;
  localparam int unsigned BW = 7;
  localparam int unsigned AW = 29;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // contiguous instance
  logic [AW-1:0]        s_address;
  logic [BW-1:0]        s_burstcount;
  logic                 s_read, s_write;
  logic [DW-1:0]        s_writedata;
  logic [DW/8-1:0]      s_byteenable;
  logic                 s_waitrequest;
  logic [DW-1:0]        s_readdata;
  logic                 s_readdatavalid;
  logic [NB*BA-1:0]     m_address;
  logic [NB*BW-1:0]     m_burstcount;
  logic [NB-1:0]        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [NB*DW-1:0]     m_writedata, m_readdata;
  logic [NB*DW/8-1:0]   m_byteenable;
  logic                 err_burst_cross;
  logic [NB*32-1:0]     perf_rd_beats, perf_wr_beats;

  // interleaved instance
  logic [AW-1:0]        b_s_address;
  logic [BW-1:0]        b_s_burstcount;
  logic                 b_s_read, b_s_write;
  logic [DW-1:0]        b_s_writedata;
  logic [DW/8-1:0]      b_s_byteenable;
  logic                 b_s_waitrequest;
  logic [DW-1:0]        b_s_readdata;
  logic                 b_s_readdatavalid;
  logic [NB*BA-1:0]     b_m_address;
  logic [NB*BW-1:0]     b_m_burstcount;
  logic [NB-1:0]        b_m_read, b_m_write, b_m_waitrequest, b_m_readdatavalid;
  logic [NB*DW-1:0]     b_m_writedata, b_m_readdata;
  logic [NB*DW/8-1:0]   b_m_byteenable;
  logic                 b_err_burst_cross;
  logic [NB*32-1:0]     b_perf_rd_beats, b_perf_wr_beats;

  logic                 cnt_clear, cnt_inc;
  logic [3:0]           cnt_value;

  int unsigned n_cmp;
  int unsigned n_err;

  asp_local_mem_bank_router #(
    .NUM_BANKS(NB), .DATA_W(DW), .BANK_ADDR_W(BA), .BURST_W(BW),
    .MAX_RD_BEATS(256), .INTERLEAVE(0), .INTLV_LOG2(6)
  ) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_burst_cross(err_burst_cross), .perf_rd_beats(perf_rd_beats), .perf_wr_beats(perf_wr_beats)
  );

  asp_local_mem_bank_router #(
    .NUM_BANKS(NB), .DATA_W(DW), .BANK_ADDR_W(BA), .BURST_W(BW),
    .MAX_RD_BEATS(256), .INTERLEAVE(1), .INTLV_LOG2(6)
  ) dut_i (
    .clk(clk), .reset(reset),
    .s_address(b_s_address), .s_burstcount(b_s_burstcount), .s_read(b_s_read), .s_write(b_s_write),
    .s_writedata(b_s_writedata), .s_byteenable(b_s_byteenable), .s_waitrequest(b_s_waitrequest),
    .s_readdata(b_s_readdata), .s_readdatavalid(b_s_readdatavalid),
    .m_address(b_m_address), .m_burstcount(b_m_burstcount), .m_read(b_m_read), .m_write(b_m_write),
    .m_writedata(b_m_writedata), .m_byteenable(b_m_byteenable), .m_waitrequest(b_m_waitrequest),
    .m_readdata(b_m_readdata), .m_readdatavalid(b_m_readdatavalid),
    .err_burst_cross(b_err_burst_cross), .perf_rd_beats(b_perf_rd_beats), .perf_wr_beats(b_perf_wr_beats)
  );

  asp_bank_perf_counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .i_clear(cnt_clear), .i_inc(cnt_inc), .o_count(cnt_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    s_address = '0; s_burstcount = '0; s_read = 1'b1; s_write = 1'b0;
    s_writedata = '0; s_byteenable = '1;
    m_waitrequest = '0; m_readdata = '0; m_readdatavalid = '0;
    b_s_address = '0; b_s_burstcount = '0; b_s_read = 1'b0; b_s_write = 1'b0;
    b_s_writedata = '0; b_s_byteenable = '1;
    b_m_waitrequest = '0; b_m_readdata = '0; b_m_readdatavalid = '0;
    cnt_clear = 1'b1; cnt_inc = 1'b0;

    // reset state, with a read request held during reset
    tick(); tick();
    chk("rst_waitreq", 64'(s_waitrequest), 64'd1);
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_rdv", 64'(s_readdatavalid), 64'd0);
    chk("rst_err", 64'(err_burst_cross), 64'd0);
    chk("rst_rd_out", 64'(dut.r_rd_beats_out), 64'd0);
    chk("rst_perf_rd", 64'(perf_rd_beats), 64'd0);
    chk("rst_cnt", 64'(cnt_value), 64'd0);
    reset = 1'b0; s_read = 1'b0;
    cnt_clear = 1'b0; cnt_inc = 1'b1;
    tick();

    // read burst 8 to bank 1
    s_address = 29'h0800_0000; s_burstcount = 7'd8; s_read = 1'b1;
    #1;
    chk("t1_waitreq", 64'(s_waitrequest), 64'd0);
    chk("t1_m_read", 64'(m_read), 64'b0010);
    chk("t1_m_addr", 64'(m_address[BA +: BA]), 64'd0);
    chk("t1_m_burst", 64'(m_burstcount[BW +: BW]), 64'd8);
    tick();
    s_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_readdatavalid = 4'b0010;
      m_readdata[DW +: DW] = 32'hA0 + 32'(i);
      tick();
      chk("t1_rdv", 64'(s_readdatavalid), 64'd1);
      chk("t1_rdata", 64'(s_readdata), 64'hA0 + 64'(i));
    end
    m_readdatavalid = '0;
    tick();
    chk("t1_rdv_end", 64'(s_readdatavalid), 64'd0);
    chk("t1_rd_out", 64'(dut.r_rd_beats_out), 64'd0);

    // bank switch stalled until outstanding bank-0 reads return
    s_address = '0; s_burstcount = 7'd4; s_read = 1'b1;
    #1;
    chk("t2_acc_wait", 64'(s_waitrequest), 64'd0);
    tick();
    s_address = 29'h1000_0000; s_burstcount = 7'd1;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 4'b0001;
      m_readdata[0 +: DW] = 32'hB0 + 32'(i);
      #1;
      chk("t2_stall", 64'(s_waitrequest), 64'd1);
      chk("t2_stall_m_read", 64'(m_read), 64'd0);
      tick();
    end
    m_readdatavalid = '0;
    #1;
    chk("t2_release", 64'(s_waitrequest), 64'd0);
    chk("t2_m_read", 64'(m_read), 64'b0100);
    chk("t2_last_data", 64'(s_readdata), 64'hB3);
    tick();
    s_read = 1'b0;
    m_readdatavalid = 4'b0100;
    m_readdata[2*DW +: DW] = 32'hC0;
    tick();
    m_readdatavalid = '0;
    chk("t2_b2_rdv", 64'(s_readdatavalid), 64'd1);
    chk("t2_b2_rdata", 64'(s_readdata), 64'hC0);

    // write burst 16 locked to bank 3, reads stalled in the gaps
    s_address = 29'h1800_0000; s_burstcount = 7'd16; s_write = 1'b1; s_writedata = 32'hD0;
    #1;
    chk("t3_m_write", 64'(m_write), 64'b1000);
    tick();
    for (int i = 1; i < 16; i++) begin
      s_write = 1'b0; s_read = 1'b1; s_burstcount = 7'd1;
      s_address = AW'(i % 4) << 27;
      #1;
      chk("t3_rd_stall", 64'(s_waitrequest), 64'd1);
      chk("t3_rd_m_read", 64'(m_read), 64'd0);
      tick();
      s_read = 1'b0; s_write = 1'b1; s_writedata = 32'hD0 + 32'(i);
      #1;
      chk("t3_m_write", 64'(m_write), 64'b1000);
      chk("t3_wdata", 64'(m_writedata[3*DW +: DW]), 64'hD0 + 64'(i));
      tick();
    end
    s_write = 1'b0; s_read = 1'b1; s_address = '0;
    #1;
    chk("t3_idle_wait", 64'(s_waitrequest), 64'd0);
    chk("t3_idle_m_read", 64'(m_read), 64'b0001);
    chk("t3_state", 64'(dut.r_state), 64'd0);
    s_read = 1'b0;
`ifdef ASP_BANK_ROUTER_PERF_EN
    chk("t3_perf_wr3", 64'(perf_wr_beats[3*32 +: 32]), 64'd16);
    chk("t3_perf_rd1", 64'(perf_rd_beats[1*32 +: 32]), 64'd8);
    chk("t3_perf_rd0", 64'(perf_rd_beats[0 +: 32]), 64'd4);
    chk("t3_perf_rd2", 64'(perf_rd_beats[2*32 +: 32]), 64'd1);
`else
    chk("t3_perf_wr_off", 64'(perf_wr_beats), 64'd0);
    chk("t3_perf_rd_off", 64'(perf_rd_beats), 64'd0);
`endif

    // outstanding-read ceiling
    for (int k = 0; k < 4; k++) begin
      s_read = 1'b1; s_address = '0; s_burstcount = 7'd64;
      #1;
      chk("t4_acc", 64'(s_waitrequest), 64'd0);
      tick();
    end
    chk("t4_peak", 64'(dut.r_rd_beats_out), 64'd256);
    for (int i = 0; i < 64; i++) begin
      m_readdatavalid = 4'b0001;
      #1;
      chk("t4_stall", 64'(s_waitrequest), 64'd1);
      tick();
    end
    m_readdatavalid = '0;
    #1;
    chk("t4_release", 64'(s_waitrequest), 64'd0);
    chk("t4_m_read", 64'(m_read), 64'b0001);
    tick();
    s_read = 1'b0;
    chk("t4_refill", 64'(dut.r_rd_beats_out), 64'd256);
    m_readdatavalid = 4'b0001;
    repeat (256) tick();
    m_readdatavalid = '0;
    tick();
    chk("t4_drained", 64'(dut.r_rd_beats_out), 64'd0);
    chk("t4_rdv_end", 64'(s_readdatavalid), 64'd0);

    // interleaved decode and granule-cross flag
    b_s_address = 29'h145;
    #1;
    chk("t5_strip_addr", 64'(b_m_address[BA +: BA]), 64'h45);
    chk("t5_idle_m_read", 64'(b_m_read), 64'd0);
    b_s_address = 29'd64; b_s_burstcount = 7'd4; b_s_read = 1'b1;
    #1;
    chk("t5_b1_m_read", 64'(b_m_read), 64'b0010);
    chk("t5_b1_addr", 64'(b_m_address[BA +: BA]), 64'd0);
    tick();
    b_s_read = 1'b0;
    chk("t5_no_err", 64'(b_err_burst_cross), 64'd0);
    b_m_readdatavalid = 4'b0010;
    repeat (4) tick();
    b_m_readdatavalid = '0;
    b_s_address = 29'd60; b_s_burstcount = 7'd8; b_s_read = 1'b1;
    #1;
    chk("t5_b0_m_read", 64'(b_m_read), 64'b0001);
    chk("t5_b0_addr", 64'(b_m_address[0 +: BA]), 64'd60);
    tick();
    b_s_read = 1'b0;
    chk("t5_err", 64'(b_err_burst_cross), 64'd1);
    chk("t5_contig_no_err", 64'(err_burst_cross), 64'd0);

    // reset in the middle of a write burst
    s_address = 29'h1000_0000; s_burstcount = 7'd8; s_write = 1'b1;
    tick(); tick(); tick();
    chk("t6_wr_left", 64'(dut.r_wr_left), 64'd5);
    reset = 1'b1;
    #1;
    chk("t6_m_write", 64'(m_write), 64'd0);
    chk("t6_waitreq", 64'(s_waitrequest), 64'd1);
    tick();
    chk("t6_state", 64'(dut.r_state), 64'd0);
    chk("t6_waitreq_hold", 64'(s_waitrequest), 64'd1);
    chk("t6_perf_wr", 64'(perf_wr_beats), 64'd0);
    chk("t6_perf_rd", 64'(perf_rd_beats), 64'd0);
    chk("t6_err_clr", 64'(b_err_burst_cross), 64'd0);
    reset = 1'b0; s_write = 1'b0;
    m_readdatavalid = 4'b0001;
    tick();
    m_readdatavalid = '0;
    chk("t6_drop", 64'(s_readdatavalid), 64'd0);
    s_write = 1'b1; s_address = '0; s_burstcount = 7'd1;
    #1;
    chk("t6_idle_write", 64'(m_write), 64'b0001);
    s_write = 1'b0;

    // saturating counter
    chk("cnt_sat", 64'(cnt_value), 64'd15);
    cnt_clear = 1'b1;
    tick();
    chk("cnt_clear", 64'(cnt_value), 64'd0);
    cnt_clear = 1'b0;
    repeat (3) tick();
    chk("cnt_inc", 64'(cnt_value), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/asp_local_mem_bank_router.md
Name: asp_local_mem_bank_router

Overview:
- Parametrised N-bank local-memory router in the ASP AFU shell.
- Presents one flat Avalon-MM burst slave (kernel/DMA side) and fans it out to NUM_BANKS per-bank Avalon-MM masters, which connect to the PIM-mapped local memory banks.
- Supports contiguous or interleaved bank mapping.
- Keeps read data in order by stalling bank switches while reads are outstanding.
- Locks write bursts to a single bank.

Parameters:
- NUM_BANKS, 4, bank count (power of two, 1..8).
- DATA_W, 512, data width in bits.
- BANK_ADDR_W, 27, per-bank word address width.
- BURST_W, 7, burstcount width (max burst 2^(BURST_W-1)).
- MAX_RD_BEATS, 256, maximum outstanding read beats accepted.
- INTERLEAVE, 0, 0 = contiguous (bank = top address bits), 1 = interleaved (bank = address bits [INTLV_LOG2 +: log2(NUM_BANKS)]).
- INTLV_LOG2, 6, interleave granule in words (log2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- s_address  in  BANK_ADDR_W+log2(NUM_BANKS)  word address, valid on first beat.
- s_burstcount  in  BURST_W  burst length.
- s_read / s_write  in  1  command strobes.
- s_writedata  in  DATA_W.
- s_byteenable  in  DATA_W/8.
- s_waitrequest  out  1.
- s_readdata  out  DATA_W.
- s_readdatavalid  out  1.
- m_address  out  NUM_BANKS*BANK_ADDR_W.
- m_burstcount  out  NUM_BANKS*BURST_W.
- m_read / m_write  out  NUM_BANKS.
- m_writedata  out  NUM_BANKS*DATA_W.
- m_byteenable  out  NUM_BANKS*DATA_W/8.
- m_waitrequest  in  NUM_BANKS.
- m_readdata  in  NUM_BANKS*DATA_W.
- m_readdatavalid  in  NUM_BANKS.
- err_burst_cross  out  1  sticky: interleaved burst crossed a granule.
- perf_rd_beats / perf_wr_beats  out  NUM_BANKS*32  per-bank beat counters (see Optional Feature).

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values:
  - m_read = 0, m_write = 0, s_readdatavalid = 0, s_waitrequest = 1, err_burst_cross = 0.
  - state = IDLE, rd_bank = 0, rd_beats_out = 0, perf counters = 0.
- Bank decode:
  - Contiguous: bank = s_address[MSBs].
  - Interleaved: bank = s_address[INTLV_LOG2 +: log2 NUM_BANKS]; bank address = s_address with the bank field removed.
  - NUM_BANKS = 1: bank = 0 and the address passes through.
- Command path is combinational: the selected bank's m_* = s_*; all other banks see m_read/m_write = 0.
- s_waitrequest = m_waitrequest[bank] | stall.
- A command or beat is accepted when (s_read | s_write) & ~s_waitrequest.
- State machine:
  - IDLE:
    - An accepted write with burstcount > 1 latches wr_bank and wr_left = burstcount-1, then moves to WR_BURST.
    - An accepted single-beat write stays in IDLE.
  - WR_BURST:
    - All write beats route to wr_bank, ignoring s_address.
    - s_read is stalled.
    - wr_left decrements per accepted beat; return to IDLE when it reaches 0 on acceptance.
- Read stall rule. A read is stalled when either:
  - rd_beats_out != 0 and the decoded bank != rd_bank, or
  - rd_beats_out + s_burstcount > MAX_RD_BEATS.
- Read accounting:
  - An accepted read sets rd_bank = bank and adds burstcount to rd_beats_out.
  - Each m_readdatavalid[rd_bank] beat decrements rd_beats_out.
  - A read accept and a return beat in the same cycle give a net change of burstcount-1.
  - rd_beats_out width = clog2(MAX_RD_BEATS)+1; it never wraps.
- Read return: s_readdata/s_readdatavalid are registered from bank rd_bank, with 1-cycle latency and no backpressure.
  - readdatavalid from any bank other than rd_bank is a protocol violation; it is ignored and the simulation assertion fires.
- Writes are not blocked by outstanding reads. Avalon per-slave ordering is preserved because each bank is a separate slave.
- Error checking (INTERLEAVE = 1): err_burst_cross sets when an accepted burst's (address mod 2^INTLV_LOG2) + burstcount > 2^INTLV_LOG2.
  - The command is still forwarded to the first beat's bank.
  - The flag clears only on reset.
- Reset mid-burst: state returns to IDLE and rd_beats_out returns to 0. In-flight bank responses arriving after reset are dropped.

Optional Feature:
- Macro: ASP_BANK_ROUTER_PERF_EN.
- Defined: per-bank 32-bit saturating counters.
  - perf_rd_beats counts m_readdatavalid beats.
  - perf_wr_beats counts accepted write beats.
  - Counters clear on reset.
- Undefined: the perf ports stay present but are tied to 0, and no counter logic is generated.

Decomposition:
- Shared package asp_mem_router_pkg holds:
  - t_router_state enum (IDLE, WR_BURST).
  - Function bank_sel(addr, mode).
  - Localparams BANK_SEL_W and RD_CNT_W.
- One natural sub-module: asp_bank_perf_counter, a saturating 32-bit counter with increment and clear, instantiated 2*NUM_BANKS times under the macro.

Test Plan:
- Contiguous, NUM_BANKS=4: read burst 8 at address 0x0800_0000 -> bank 1 gets address 0, burstcount 8; 8 readdatavalid beats returned in order, 1 cycle later each.
- Read burst 4 to bank 0, then immediate read to bank 2 -> s_waitrequest held high until the 4th bank-0 beat returns; the bank-2 read issues on the following cycle.
- Write burst 16 to bank 3 with the address changing on beats 2..16 -> all 16 beats go to bank 3; state returns to IDLE after beat 16; a concurrent s_read is stalled throughout.
- MAX_RD_BEATS=256: issue 4 bursts of 64 to one bank, then a 5th -> the 5th is stalled until at least 64 beats have returned; rd_beats_out peaks at 256.
- INTERLEAVE=1, INTLV_LOG2=6: burst 8 at word 60 -> err_burst_cross=1 and the command goes to the bank of word 60. Burst 4 at word 64 -> bank 1, no error.
- Assert reset during WR_BURST with wr_left=5 -> next cycle m_write=0, state IDLE, s_waitrequest=1; with PERF_EN, counters read 0.
